imem_arbiter: RTL and testbench

- Arbitrates a single-port, synchronous-read 32-bit instruction/program RAM (one-cycle read latency, word-addressed, byte-lane writes) between two requesters.
- Port 0 is the CPU fetch/load path. Port 1 is the program loader/debug path.
- Converts byte addresses plus memop into word address, byte enables and write-data lane placement.
- Extracts, sign-extends or zero-extends read data and returns it with a per-port response strobe.

---
 rtl/imem_arbiter.sv | 155 +++++++++++++++
 tb/tb_imem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// +--------------------------------------------------------------------------+
// | imem_arbiter: two-port arbiter for a 1-cycle-latency 32-bit program RAM   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_arbiter #(
    parameter int ADDR_W = 12,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [31:0]       addr0,
    input  logic              we0,
    input  logic [2:0]        memop0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic              err0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic [31:0]       addr1,
    input  logic              we1,
    input  logic [2:0]        memop1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic              err1,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [2:0]  memop_q, memop_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;

    logic        w_grant, w_sel, w_we, w_err, w_misalign, w_valid_op;
    logic [31:0] w_addr, w_wdata, w_ext, w_resp_data;
    logic [2:0]  w_memop;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            memop_q <= 3'b000;
            off_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            memop_q <= memop_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        port_d    = port_q;
        we_d      = we_q;
        memop_d   = memop_q;
        off_d     = off_q;
        err_d     = err_q;
        w_grant   = (state_q == S_IDLE) && (req0 || req1);
        // On a tie, last_q names the previous winner; the other port goes next.
        if (req0 && req1) w_sel = RR_EN ? ~last_q : 1'b0;
        else              w_sel = ~req0;
        w_addr    = w_sel ? addr1  : addr0;
        w_we      = w_sel ? we1    : we0;
        w_memop   = w_sel ? memop1 : memop0;
        w_wdata   = w_sel ? wdata1 : wdata0;
        w_valid_op = (w_memop == 3'b000) || (w_memop == 3'b001) || (w_memop == 3'b010)
                  || (w_memop == 3'b100) || (w_memop == 3'b101);
        case (w_memop[1:0])
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_addr[0];
            2'b10:   w_misalign = |w_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
        w_err     = !w_valid_op || w_misalign;
        gnt0      = w_grant && !w_sel;
        gnt1      = w_grant && w_sel;
        ram_addr  = w_addr[ADDR_W+1:2];
        ram_we    = w_grant && w_we && !w_err;
        ram_be    = 4'b0000;
        case (w_memop[1:0])
            2'b00:   ram_wdata = {4{w_wdata[7:0]}};
            2'b01:   ram_wdata = {2{w_wdata[15:0]}};
            default: ram_wdata = w_wdata;
        endcase
        if (ram_we) begin
            case (w_memop[1:0])
                2'b00:   ram_be = 4'b0001 << w_addr[1:0];
                2'b01:   ram_be = w_addr[1] ? 4'b1100 : 4'b0011;
                default: ram_be = 4'b1111;
            endcase
        end
        if (w_grant) begin
            state_d = S_RESP;
            last_d  = w_sel;
            port_d  = w_sel;
            we_d    = w_we;
            memop_d = w_memop;
            off_d   = w_addr[1:0];
            err_d   = w_err;
        end else if (state_q == S_RESP) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        w_byte = ram_rdata[8*off_q +: 8];
        w_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (memop_q)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            3'b010:  w_ext = ram_rdata;
            default: w_ext = 32'h0;
        endcase
        w_resp_data = (we_q || err_q) ? 32'h0 : w_ext;
        rvalid0     = (state_q == S_RESP) && !port_q;
        rvalid1     = (state_q == S_RESP) && port_q;
        err0        = rvalid0 && err_q;
        err1        = rvalid1 && err_q;
        rdata0      = rvalid0 ? w_resp_data : 32'h0;
        rdata1      = rvalid1 ? w_resp_data : 32'h0;
    end

    // Address bits above the RAM depth are intentionally ignored.
    assign w_unused = &{1'b0, w_addr[31:ADDR_W+2]};

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_imem_arbiter: vector table + response scoreboard for imem_arbiter      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_imem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_load;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [2:0]  memop0, memop1;
    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata, ram_rdata;

    logic        fp_gnt0, fp_gnt1;
    logic        unused_fp_rv0, unused_fp_err0, unused_fp_rv1, unused_fp_err1, unused_fp_we;
    logic [31:0] unused_fp_rd0, unused_fp_rd1, unused_fp_wdata;
    logic [11:0] unused_fp_addr;
    logic [3:0]  unused_fp_be;

    imem_arbiter #(.ADDR_W(12), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .we0(we0), .memop0(memop0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .memop1(memop1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .err1(err1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    imem_arbiter #(.ADDR_W(12), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .we0(we0), .memop0(memop0), .wdata0(wdata0),
        .gnt0(fp_gnt0), .rvalid0(unused_fp_rv0), .err0(unused_fp_err0), .rdata0(unused_fp_rd0),
        .req1(req1), .addr1(addr1), .we1(we1), .memop1(memop1), .wdata1(wdata1),
        .gnt1(fp_gnt1), .rvalid1(unused_fp_rv1), .err1(unused_fp_err1), .rdata1(unused_fp_rd1),
        .ram_addr(unused_fp_addr), .ram_we(unused_fp_we), .ram_be(unused_fp_be),
        .ram_wdata(unused_fp_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous-read RAM model with byte-lane writes (16 words are enough).
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h11223344;
            mem[1] <= 32'h80015678;
            mem[2] <= 32'hDEADBEEF;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr[3:0]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } resp_t;
    resp_t sbq[$];
    resp_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid0 && rvalid1) begin
                check("both_rvalid", 32'd1, 32'd0);
            end else if (rvalid0 || rvalid1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("resp_port", {31'b0, rvalid1}, {31'b0, mon_e.port});
                    check("resp_err", {31'b0, rvalid1 ? err1 : err0}, {31'b0, mon_e.err});
                    check("resp_rdata", rvalid1 ? rdata1 : rdata0, mon_e.rdata);
                end
            end else begin
                check("idle_rdata", rdata0 | rdata1, 32'h0);
            end
        end
    end

    typedef struct {
        string       name;
        logic        port;
        logic [31:0] addr;
        logic        we;
        logic [2:0]  memop;
        logic [31:0] wdata;
        logic [11:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic p, input logic [31:0] a,
                                input logic w, input logic [2:0] op, input logic [31:0] wd,
                                input logic [11:0] ea, input logic ewe, input logic [3:0] ebe,
                                input logic [31:0] ewd, input logic eerr, input logic [31:0] erd);
        vec_t v;
        v.name = n; v.port = p; v.addr = a; v.we = w; v.memop = op; v.wdata = wd;
        v.e_addr = ea; v.e_we = ewe; v.e_be = ebe; v.e_wdata = ewd;
        v.e_err = eerr; v.e_rdata = erd;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends the grant cycle.
    task automatic run_vec(input vec_t v);
        logic g, other;
        bit   done;
        done = 0;
        if (v.port) begin
            req1 = 1'b1; addr1 = v.addr; we1 = v.we; memop1 = v.memop; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; addr0 = v.addr; we0 = v.we; memop0 = v.memop; wdata0 = v.wdata;
        end
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            g     = v.port ? gnt1 : gnt0;
            other = v.port ? gnt0 : gnt1;
            if (g) begin
                done = 1;
                check({v.name, ".other_gnt"}, {31'b0, other}, 32'd0);
                check({v.name, ".ram_addr"}, {20'b0, ram_addr}, {20'b0, v.e_addr});
                check({v.name, ".ram_we"}, {31'b0, ram_we}, {31'b0, v.e_we});
                check({v.name, ".ram_be"}, {28'b0, ram_be}, {28'b0, v.e_be});
                if (v.e_be != 4'b0000) check({v.name, ".ram_wdata"}, ram_wdata, v.e_wdata);
                sbq.push_back('{port: v.port, err: v.e_err, rdata: v.e_rdata});
            end
            @(posedge clk); #1;
        end
        if (!done) check({v.name, ".gnt_timeout"}, 32'd0, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_load = 1'b1;
        req0 = 1'b0; addr0 = '0; we0 = 1'b0; memop0 = 3'b010; wdata0 = '0;
        req1 = 1'b0; addr1 = '0; we1 = 1'b0; memop1 = 3'b010; wdata1 = '0;

        //         name        p  addr          we op      wdata         eaddr   ewe ebe      ewdata        err erdata
        vecs.push_back(mk("lw_8",     0, 32'h8,        0, 3'b010, 32'h0,        12'h002, 0, 4'b0000, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk("sb_5",     1, 32'h5,        1, 3'b000, 32'h000000AB, 12'h001, 1, 4'b0010, 32'hABABABAB, 0, 32'h0));
        vecs.push_back(mk("lb_5",     0, 32'h5,        0, 3'b000, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        0, 32'hFFFFFFAB));
        vecs.push_back(mk("lbu_5",    0, 32'h5,        0, 3'b100, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        0, 32'h000000AB));
        vecs.push_back(mk("lh_6",     1, 32'h6,        0, 3'b001, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        0, 32'hFFFF8001));
        vecs.push_back(mk("lhu_6",    0, 32'h6,        0, 3'b101, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        0, 32'h00008001));
        vecs.push_back(mk("sh_2",     1, 32'h2,        1, 3'b001, 32'h1234CAFE, 12'h000, 1, 4'b1100, 32'hCAFECAFE, 0, 32'h0));
        vecs.push_back(mk("sw_c",     0, 32'hC,        1, 3'b010, 32'h0BADF00D, 12'h003, 1, 4'b1111, 32'h0BADF00D, 0, 32'h0));
        vecs.push_back(mk("lw_c",     1, 32'hC,        0, 3'b010, 32'h0,        12'h003, 0, 4'b0000, 32'h0,        0, 32'h0BADF00D));
        vecs.push_back(mk("lw_0",     0, 32'h0,        0, 3'b010, 32'h0,        12'h000, 0, 4'b0000, 32'h0,        0, 32'hCAFE3344));
        vecs.push_back(mk("lb_3",     1, 32'h3,        0, 3'b000, 32'h0,        12'h000, 0, 4'b0000, 32'h0,        0, 32'hFFFFFFCA));
        vecs.push_back(mk("lbu_0",    0, 32'h0,        0, 3'b100, 32'h0,        12'h000, 0, 4'b0000, 32'h0,        0, 32'h00000044));
        vecs.push_back(mk("sbu_7",    1, 32'h7,        1, 3'b100, 32'h0000005A, 12'h001, 1, 4'b1000, 32'h5A5A5A5A, 0, 32'h0));
        vecs.push_back(mk("lw_4",     0, 32'h4,        0, 3'b010, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        0, 32'h5A01AB78));
        vecs.push_back(mk("lh_4",     0, 32'h4,        0, 3'b001, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        0, 32'hFFFFAB78));
        vecs.push_back(mk("lb_4",     1, 32'h4,        0, 3'b000, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        0, 32'h00000078));
        vecs.push_back(mk("e_lw_6",   0, 32'h6,        0, 3'b010, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        1, 32'h0));
        vecs.push_back(mk("e_sh_3",   1, 32'h3,        1, 3'b001, 32'h0000FFFF, 12'h000, 0, 4'b0000, 32'h0,        1, 32'h0));
        vecs.push_back(mk("e_op011",  0, 32'h8,        0, 3'b011, 32'h0,        12'h002, 0, 4'b0000, 32'h0,        1, 32'h0));
        vecs.push_back(mk("e_sw110",  1, 32'h0,        1, 3'b110, 32'hFFFFFFFF, 12'h000, 0, 4'b0000, 32'h0,        1, 32'h0));
        vecs.push_back(mk("lw_0_chk", 0, 32'h0,        0, 3'b010, 32'h0,        12'h000, 0, 4'b0000, 32'h0,        0, 32'hCAFE3344));
        vecs.push_back(mk("e_lh_5",   1, 32'h5,        0, 3'b001, 32'h0,        12'h001, 0, 4'b0000, 32'h0,        1, 32'h0));
        vecs.push_back(mk("lw_hi",    1, 32'hFFFFC008, 0, 3'b010, 32'h0,        12'h002, 0, 4'b0000, 32'h0,        0, 32'hDEADBEEF));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.gnt", {30'b0, gnt1, gnt0}, 32'd0);
        check("rst.rvalid_err", {28'b0, rvalid1, err1, rvalid0, err0}, 32'd0);
        check("rst.ram_we_be", {27'b0, ram_we, ram_be}, 32'd0);
        check("rst.rdata", rdata0 | rdata1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_load = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the response cycle of a port-0 read.
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 32'h8; we0 = 1'b0; memop0 = 3'b010;
        @(negedge clk);
        check("rstmid.gnt0", {31'b0, gnt0}, 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstmid.rvalid0", {31'b0, rvalid0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Both ports hold requests: round-robin alternates from port 0, fixed priority keeps port 0.
        req0 = 1'b1; addr0 = 32'h8; we0 = 1'b0; memop0 = 3'b010;
        req1 = 1'b1; addr1 = 32'hC; we1 = 1'b0; memop1 = 3'b010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rr.gnt0[%0d]", k), {31'b0, gnt0}, {31'b0, (k % 4) == 0});
            check($sformatf("rr.gnt1[%0d]", k), {31'b0, gnt1}, {31'b0, (k % 4) == 2});
            check($sformatf("fp.gnt0[%0d]", k), {31'b0, fp_gnt0}, {31'b0, (k % 2) == 0});
            check($sformatf("fp.gnt1[%0d]", k), {31'b0, fp_gnt1}, 32'd0);
            if ((k % 4) == 0) sbq.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF});
            if ((k % 4) == 2) sbq.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0BADF00D});
            @(posedge clk);
        end
        #1;
        req0 = 1'b0; req1 = 1'b0;

        // Port 1 pulses a write request only during port 0's response cycle.
        run_vec(mk("wd_lw_8", 0, 32'h8, 0, 3'b010, 32'h0, 12'h002, 0, 4'b0000, 32'h0, 0, 32'hDEADBEEF));
        req1 = 1'b1; addr1 = 32'h0; we1 = 1'b1; memop1 = 3'b010; wdata1 = 32'hFFFFFFFF;
        @(negedge clk);
        check("wd.gnt_in_resp", {30'b0, gnt1, gnt0}, 32'd0);
        check("wd.ram_in_resp", {27'b0, ram_we, ram_be}, 32'd0);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        check("wd.gnt_after", {30'b0, gnt1, gnt0}, 32'd0);
        check("wd.ram_after", {27'b0, ram_we, ram_be}, 32'd0);
        @(posedge clk); #1;
        run_vec(mk("wd_lw_0", 0, 32'h0, 0, 3'b010, 32'h0, 12'h000, 0, 4'b0000, 32'h0, 0, 32'hCAFE3344));

        repeat (3) @(posedge clk);
        #1;
        check("sb.drained", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
